// File: rtl/car_kinematics.sv
// Race-car longitudinal kinematics: IDLE/RACE/FINISHED control with a
// per-gear speed model, integrated position and a race timer.
module car_kinematics #(
    parameter logic [31:0] FINISH_POS = 32'd400000,
    parameter int          TIME_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              throttle,
    input  logic              shift_up,
    input  logic              shift_down,
    output logic [31:0]       position,
    output logic [7:0]        speed,
    output logic [2:0]        gear,
    output logic [TIME_W-1:0] race_time,
    output logic              racing,
    output logic              finished
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RACE     = 2'd1,
        FINISHED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       position_q, position_d;
    logic [7:0]        speed_q, speed_d;
    logic [2:0]        gear_q, gear_d;
    logic [TIME_W-1:0] race_time_q, race_time_d;
    logic              up_q, dn_q;

    logic              up_rise, dn_rise;
    logic [7:0]        vmax, accel;
    logic [8:0]        spd_sum;
    logic [32:0]       pos_sum;

    function automatic logic [7:0] vmax_of(input logic [2:0] g);
        case (g)
            3'd1:    return 8'd60;
            3'd2:    return 8'd110;
            3'd3:    return 8'd160;
            3'd4:    return 8'd210;
            default: return 8'd255;
        endcase
    endfunction

    function automatic logic [7:0] accel_of(input logic [2:0] g);
        case (g)
            3'd1:    return 8'd4;
            3'd2:    return 8'd3;
            3'd3:    return 8'd2;
            3'd4:    return 8'd2;
            default: return 8'd1;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        position_d  = position_q;
        speed_d     = speed_q;
        gear_d      = gear_q;
        race_time_d = race_time_q;

        up_rise = shift_up & ~up_q;
        dn_rise = shift_down & ~dn_q;
        // Speed limits come from the gear held before this edge, so a shift
        // that lands with a tick only affects the following tick.
        vmax    = vmax_of(gear_q);
        accel   = accel_of(gear_q);
        spd_sum = {1'b0, speed_q} + {1'b0, accel};
        pos_sum = {1'b0, position_q} + {25'd0, speed_q};

        case (state_q)
            RACE: begin
                if (up_rise && !dn_rise && gear_q != 3'd5) begin
                    gear_d = gear_q + 3'd1;
                end else if (dn_rise && !up_rise && gear_q != 3'd1) begin
                    gear_d = gear_q - 3'd1;
                end

                if (tick) begin
                    if (speed_q > vmax) begin
                        speed_d = (speed_q - 8'd2 > vmax) ? speed_q - 8'd2 : vmax;
                    end else if (throttle) begin
                        speed_d = (spd_sum > {1'b0, vmax}) ? vmax : spd_sum[7:0];
                    end else begin
                        speed_d = (speed_q == 8'd0) ? 8'd0 : speed_q - 8'd1;
                    end
                    position_d  = pos_sum[32] ? 32'hFFFF_FFFF : pos_sum[31:0];
                    race_time_d = (&race_time_q) ? race_time_q : race_time_q + TIME_W'(1);
                    if (position_d >= FINISH_POS) begin
                        state_d = FINISHED;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d     = RACE;
                    position_d  = '0;
                    speed_d     = '0;
                    gear_d      = 3'd1;
                    race_time_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            position_q  <= '0;
            speed_q     <= '0;
            gear_q      <= 3'd1;
            race_time_q <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            position_q  <= position_d;
            speed_q     <= speed_d;
            gear_q      <= gear_d;
            race_time_q <= race_time_d;
            up_q        <= shift_up;
            dn_q        <= shift_down;
        end
    end

    assign position  = position_q;
    assign speed     = speed_q;
    assign gear      = gear_q;
    assign race_time = race_time_q;
    assign racing    = (state_q == RACE);
    assign finished  = (state_q == FINISHED);

endmodule

// File: tb/tb_car_kinematics.sv
// Bench for car_kinematics: two instances (default and short finish line)
// checked every cycle against a plain-arithmetic model, plus pinned values.
module tb_car_kinematics;

    localparam int TIME_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0, start = 1'b0, throttle = 1'b0;
    logic shift_up = 1'b0, shift_down = 1'b0;

    logic [31:0]       pos_a, pos_b;
    logic [7:0]        spd_a, spd_b;
    logic [2:0]        gear_a, gear_b;
    logic [TIME_W-1:0] time_a, time_b;
    logic              rac_a, rac_b, fin_a, fin_b;

    int checks = 0;
    int failures = 0;

    car_kinematics #(.TIME_W(TIME_W)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .throttle(throttle),
        .shift_up(shift_up), .shift_down(shift_down),
        .position(pos_a), .speed(spd_a), .gear(gear_a), .race_time(time_a),
        .racing(rac_a), .finished(fin_a)
    );

    car_kinematics #(.FINISH_POS(32'd100), .TIME_W(TIME_W)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .throttle(throttle),
        .shift_up(shift_up), .shift_down(shift_down),
        .position(pos_b), .speed(spd_b), .gear(gear_b), .race_time(time_b),
        .racing(rac_b), .finished(fin_b)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    // phase: 0 = waiting for start, 1 = racing, 2 = race over
    int     vmax_t [1:5] = '{60, 110, 160, 210, 255};
    int     acc_t  [1:5] = '{4, 3, 2, 2, 1};
    longint fin_pos[2]   = '{400000, 100};
    int     m_phase[2]   = '{0, 0};
    longint m_pos  [2]   = '{0, 0};
    int     m_spd  [2]   = '{0, 0};
    int     m_gear [2]   = '{1, 1};
    int     m_time [2]   = '{0, 0};
    bit     prev_up = 0, prev_dn = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_pos[i] = 0; m_spd[i] = 0; m_gear[i] = 1; m_time[i] = 0;
            end
            prev_up = 0;
            prev_dn = 0;
        end else begin
            bit up_edge, dn_edge;
            up_edge = shift_up && !prev_up;
            dn_edge = shift_down && !prev_dn;
            for (int i = 0; i < 2; i++) begin
                if (m_phase[i] != 1) begin
                    if (start) begin
                        m_phase[i] = 1; m_pos[i] = 0; m_spd[i] = 0; m_gear[i] = 1; m_time[i] = 0;
                    end
                end else begin
                    int g_old, top;
                    g_old = m_gear[i];
                    if (up_edge && !dn_edge && m_gear[i] < 5) m_gear[i] = m_gear[i] + 1;
                    if (dn_edge && !up_edge && m_gear[i] > 1) m_gear[i] = m_gear[i] - 1;
                    if (tick) begin
                        longint np;
                        top = vmax_t[g_old];
                        np  = m_pos[i] + m_spd[i];
                        if (m_spd[i] > top)  m_spd[i] = (m_spd[i] - 2 > top) ? m_spd[i] - 2 : top;
                        else if (throttle)   m_spd[i] = (m_spd[i] + acc_t[g_old] > top) ? top : m_spd[i] + acc_t[g_old];
                        else if (m_spd[i] > 0) m_spd[i] = m_spd[i] - 1;
                        m_pos[i] = (np > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : np;
                        if (m_time[i] < (1 << TIME_W) - 1) m_time[i] = m_time[i] + 1;
                        if (m_pos[i] >= fin_pos[i]) m_phase[i] = 2;
                    end
                end
            end
            prev_up = shift_up;
            prev_dn = shift_down;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        chk("a.position",  pos_a,  m_pos[0]);
        chk("a.speed",     spd_a,  m_spd[0]);
        chk("a.gear",      gear_a, m_gear[0]);
        chk("a.race_time", time_a, m_time[0]);
        chk("a.racing",    rac_a,  m_phase[0] == 1);
        chk("a.finished",  fin_a,  m_phase[0] == 2);
        chk("b.position",  pos_b,  m_pos[1]);
        chk("b.speed",     spd_b,  m_spd[1]);
        chk("b.gear",      gear_b, m_gear[1]);
        chk("b.race_time", time_b, m_time[1]);
        chk("b.racing",    rac_b,  m_phase[1] == 1);
        chk("b.finished",  fin_b,  m_phase[1] == 2);
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_up();
        shift_up = 1'b1; step();
        shift_up = 1'b0; step();
    endtask

    initial begin
        step(3);
        chk("rst.position", pos_a, 0);
        chk("rst.gear", gear_a, 1);
        chk("rst.racing", rac_a, 0);
        chk("rst.finished", fin_a, 0);
        reset = 1'b1;
        tick = 1'b1;
        step(2);
        chk("idle.tick.position", pos_a, 0);
        tick = 1'b0;

        // Three accelerating ticks in gear 1
        start = 1'b1; step(); start = 1'b0;
        chk("start.racing", rac_a, 1);
        throttle = 1'b1; tick = 1'b1;
        step(); chk("t1.speed", spd_a, 4);  chk("t1.position", pos_a, 0);
        step(); chk("t2.speed", spd_a, 8);  chk("t2.position", pos_a, 4);
        step(); chk("t3.speed", spd_a, 12); chk("t3.position", pos_a, 12);
        chk("t3.race_time", time_a, 3);

        // Saturation at gear-1 top speed; short track finishes meanwhile
        step(20);
        chk("g1.vmax", spd_a, 60);
        chk("b.finished", fin_b, 1);
        chk("b.racing", rac_b, 0);
        chk("b.final_pos", pos_b, 112);
        chk("b.final_speed", spd_b, 32);
        chk("b.final_time", time_b, 8);
        tick = 1'b0; step(3);
        chk("hold.speed", spd_a, 60);
        tick = 1'b1;

        // Upshift coinciding with a tick still uses the old gear limit
        shift_up = 1'b1; step(); shift_up = 1'b0;
        chk("up.gear", gear_a, 2);
        chk("up.same_tick_speed", spd_a, 60);
        step(); chk("g2.first", spd_a, 63);
        step(19); chk("g2.vmax", spd_a, 110);

        shift_down = 1'b1; step(); shift_down = 1'b0;
        chk("down.gear", gear_a, 1);
        chk("down.same_tick_speed", spd_a, 110);
        step(); chk("overrev.first", spd_a, 108);
        step(24); chk("overrev.settled", spd_a, 60);
        throttle = 1'b0; step(2);
        chk("coast.speed", spd_a, 58);
        throttle = 1'b1;

        // Shift-key edge cases, with ticks stopped
        tick = 1'b0;
        shift_up = 1'b1; step(10); shift_up = 1'b0; step();
        chk("held_up.gear", gear_a, 2);
        shift_up = 1'b1; shift_down = 1'b1; step();
        shift_up = 1'b0; shift_down = 1'b0; step();
        chk("both.gear", gear_a, 2);
        pulse_up(); pulse_up(); pulse_up();
        chk("top.gear", gear_a, 5);
        pulse_up();
        chk("top.sat_gear", gear_a, 5);
        chk("b.frozen_pos", pos_b, 112);
        chk("b.frozen_gear", gear_b, 1);

        // start restarts the finished instance, ignored by the racing one
        start = 1'b1; step(); start = 1'b0;
        chk("restart.a_racing", rac_a, 1);
        chk("restart.a_gear", gear_a, 5);
        chk("restart.b_racing", rac_b, 1);
        chk("restart.b_pos", pos_b, 0);
        chk("restart.b_speed", spd_b, 0);
        chk("restart.b_time", time_b, 0);

        // Mid-race asynchronous reset
        tick = 1'b1; step(5);
        tick = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst.position", pos_a, 0);
        chk("arst.speed", spd_a, 0);
        chk("arst.gear", gear_a, 1);
        chk("arst.race_time", time_a, 0);
        chk("arst.racing", rac_a, 0);
        chk("arst.b_speed", spd_b, 0);
        step();
        reset = 1'b1;
        tick = 1'b1;
        step(3);
        chk("post_rst.racing", rac_a, 0);
        chk("post_rst.position", pos_a, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("start_tick.position", pos_a, 0);
        chk("start_tick.racing", rac_a, 1);
        step();
        chk("after_start.speed", spd_a, 4);
        step(4);
        tick = 1'b0; throttle = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
